sram_load_sched: RTL and testbench
==================================

SRAM_LOAD_SCHED -- requirements
Module: sram_load_sched

Interface
REQ-001 SHALL have parameter BUS_SIZE, default `BUS_SIZE, sparsemap bits per write beat.
REQ-002 SHALL have parameter WR_DAT_CYC_NUM, default `WR_DAT_CYC_NUM, write beats per chunk (>=2).
REQ-003 SHALL have parameter SRAM_IFM_NUM, default `SRAM_IFM_NUM, IFM SRAM chunk capacity.
REQ-004 SHALL have parameter SRAM_FILTER_NUM, default `SRAM_FILTER_NUM, filter SRAM chunk capacity.
REQ-005 SHALL have port clk_i  input  1  single clock, all logic on rising edge.
REQ-006 SHALL have port rst_i  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port start_i  input  1  one-cycle load request.
REQ-008 SHALL have port fil_chunk_num_i  input  $clog2(SRAM_FILTER_NUM)+1  filter chunks to load, sampled at start.
REQ-009 SHALL have port ifm_chunk_num_i  input  $clog2(SRAM_IFM_NUM)+1  IFM chunks to load, sampled at start.
REQ-010 SHALL have ports in_valid_i / in_ready_o  input / output  1 / 1  source beat handshake.
REQ-011 SHALL have ports in_sparsemap_i / in_nonzero_data_i  input  BUS_SIZE / BUS_SIZE*8  beat payload.
REQ-012 SHALL have ports fil_sram_wr_{sparsemap,nonzero_data,valid,dat_count,chunk_count}_o and ifm_sram_wr_{same}_o  output  BUS_SIZE, BUS_SIZE*8, 1, $clog2(WR_DAT_CYC_NUM), $clog2(SRAM_*_NUM)  SRAM write ports.
REQ-013 SHALL have ports busy_o / finish_o  output  1 / 1  load in progress / one-cycle completion pulse.

Function
REQ-014 SHALL implement FSM IDLE -> LOAD_FIL -> LOAD_IFM -> DONE -> IDLE.
REQ-015 IDLE: on start_i, latch both counts; next state LOAD_FIL if fil count>0, else LOAD_IFM if ifm count>0, else DONE.
REQ-016 in_ready_o SHALL be 1 exactly in LOAD_FIL and LOAD_IFM, decoded from registered state only (no path from in_valid_i).
REQ-017 A beat is accepted when in_valid_i && in_ready_o; payload is routed to the filter port in LOAD_FIL, IFM port in LOAD_IFM.
REQ-018 Write outputs SHALL be registered: *_wr_valid_o high the cycle after acceptance, carrying that beat's payload, dat_count and chunk_count; low otherwise; other port's valid stays 0.
REQ-019 dat_count SHALL start at 0 per chunk, increment per accepted beat, wrap WR_DAT_CYC_NUM-1 -> 0 while chunk_count increments by 1.
REQ-020 chunk_count SHALL start at 0 per phase; accepting final beat of chunk (count-1) SHALL exit phase: LOAD_FIL -> LOAD_IFM (or DONE if ifm count 0), LOAD_IFM -> DONE.
REQ-021 Source stalls (in_valid_i low) SHALL hold all counters; no bubble insertion by the block beyond stalls.
REQ-022 DONE lasts one cycle; finish_o high exactly during DONE, coinciding with the final wr_valid_o beat (or the cycle after start when both counts 0).
REQ-023 busy_o SHALL be high in every state except IDLE.
REQ-024 start_i outside IDLE SHALL be ignored; latched counts unchanged.
REQ-025 Counts above SRAM capacity SHALL be saturated to SRAM_*_NUM at latch.

Reset
REQ-026 With rst_i low at a rising edge: state IDLE, all counters 0, all *_valid_o/busy_o/finish_o/in_ready_o 0, payload outputs 0.
REQ-027 Reset mid-load SHALL abort immediately; no finish_o pulse; next start restarts from chunk 0.

Structure
REQ-028 FSM state enum and count-width localparams SHALL live in shared package npu_mem_pkg.
REQ-029 Beat/chunk counter SHALL be sub-module sram_wr_addr_cnt (inc, clear, wrap, last flag), instantiated once per SRAM.
REQ-030 Target size 120-400 RTL lines; no latches, no combinational loops.

Verification (WR_DAT_CYC_NUM=4)
REQ-031 start, fil=2, ifm=3, in_valid_i always 1 -> 8 fil beats (chunk 0..1, dat 0..3), then 12 ifm beats (chunk 0..2); finish_o on cycle of 20th beat.
REQ-032 fil=0, ifm=1 -> no fil valid; 4 ifm beats chunk 0; finish_o with 4th.
REQ-033 fil=0, ifm=0 -> in_ready_o never 1; finish_o one cycle after start; busy_o high 1 cycle.
REQ-034 fil=1, ifm=1, in_valid_i toggling 1/0 -> counters hold on stalls; 8 total beats, payload order preserved.
REQ-035 start repeated during LOAD_IFM with different counts -> ignored, original totals completed.
REQ-036 rst_i low mid fil chunk 1 -> all outputs 0 next cycle, no finish_o; new start fil=1 writes chunk 0 dat 0 first.

Source files
------------

// File: rtl/npu_mem_pkg.sv
// -----------------------------------------------------------------------------
// npu_mem_pkg
// Shared definitions for the NPU memory-load blocks: the load-scheduler state
// encoding, default build-time sizes and the counter widths derived from them.
// No ports (package).
// -----------------------------------------------------------------------------
`ifndef BUS_SIZE
`define BUS_SIZE 8
`endif
`ifndef WR_DAT_CYC_NUM
`define WR_DAT_CYC_NUM 4
`endif
`ifndef SRAM_IFM_NUM
`define SRAM_IFM_NUM 8
`endif
`ifndef SRAM_FILTER_NUM
`define SRAM_FILTER_NUM 8
`endif

package npu_mem_pkg;

    // Load scheduler phases: filters are always loaded before IFM data.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LOAD_FIL = 2'd1,
        ST_LOAD_IFM = 2'd2,
        ST_DONE     = 2'd3
    } sched_state_e;

    // Default sizes and the counter widths that follow from them.
    localparam int DEF_BUS_SIZE        = `BUS_SIZE;
    localparam int DEF_WR_DAT_CYC_NUM  = `WR_DAT_CYC_NUM;
    localparam int DEF_SRAM_IFM_NUM    = `SRAM_IFM_NUM;
    localparam int DEF_SRAM_FILTER_NUM = `SRAM_FILTER_NUM;

    localparam int DAT_CNT_W     = $clog2(DEF_WR_DAT_CYC_NUM);
    localparam int IFM_CHUNK_W   = $clog2(DEF_SRAM_IFM_NUM);
    localparam int FIL_CHUNK_W   = $clog2(DEF_SRAM_FILTER_NUM);
    localparam int IFM_CHUNK_N_W = IFM_CHUNK_W + 1;
    localparam int FIL_CHUNK_N_W = FIL_CHUNK_W + 1;

endpackage : npu_mem_pkg

// File: rtl/sram_wr_addr_cnt.sv
// -----------------------------------------------------------------------------
// sram_wr_addr_cnt
// Beat/chunk write-address counter for one SRAM. The beat counter wraps every
// DAT_NUM accepted beats and bumps the chunk counter; last_o flags the final
// beat of the final requested chunk.
// Ports:
//   clk_i, rst_i   clock, synchronous active-low reset
//   clr_i          restart both counters at zero (new load)
//   inc_i          one beat accepted this cycle
//   chunk_num_i    number of chunks in this phase (already saturated)
//   dat_o/chunk_o  address of the beat being accepted now
//   last_o         accepting now completes the phase
// -----------------------------------------------------------------------------
module sram_wr_addr_cnt #(
    parameter  int DAT_NUM   = 4,
    parameter  int CHUNK_NUM = 8,
    localparam int DW        = $clog2(DAT_NUM),
    localparam int CW        = $clog2(CHUNK_NUM)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clr_i,
    input  logic          inc_i,
    input  logic [CW:0]   chunk_num_i,
    output logic [DW-1:0] dat_o,
    output logic [CW-1:0] chunk_o,
    output logic          last_o
);

    logic [DW-1:0] dat_q, dat_d;
    logic [CW-1:0] chunk_q, chunk_d;
    logic          dat_last;

    assign dat_last = (dat_q == DW'(DAT_NUM - 1));
    assign last_o   = dat_last && ({1'b0, chunk_q} == (chunk_num_i - (CW + 1)'(1)));

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        dat_d   = dat_q;
        chunk_d = chunk_q;
        if (clr_i) begin
            dat_d   = '0;
            chunk_d = '0;
        end else if (inc_i) begin
            dat_d = dat_last ? '0 : dat_q + DW'(1);
            if (dat_last) begin
                chunk_d = (chunk_q == CW'(CHUNK_NUM - 1)) ? '0 : chunk_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_i) begin
            dat_q   <= '0;
            chunk_q <= '0;
        end else begin
            dat_q   <= dat_d;
            chunk_q <= chunk_d;
        end
    end

    assign dat_o   = dat_q;
    assign chunk_o = chunk_q;

endmodule : sram_wr_addr_cnt

// File: rtl/sram_load_sched.sv
// -----------------------------------------------------------------------------
// sram_load_sched
// Schedules a load of filter chunks followed by IFM chunks from a single
// valid/ready beat source into the filter and IFM SRAM write ports.
// Ports:
//   clk_i, rst_i                 clock, synchronous active-low reset
//   start_i                      one-cycle load request (honoured in IDLE only)
//   fil_chunk_num_i              filter chunks to load (saturated to capacity)
//   ifm_chunk_num_i              IFM chunks to load (saturated to capacity)
//   in_valid_i / in_ready_o      source beat handshake
//   in_sparsemap_i               beat sparsemap, BUS_SIZE bits
//   in_nonzero_data_i            beat data, BUS_SIZE bytes
//   fil_sram_wr_*_o              registered filter SRAM write port
//   ifm_sram_wr_*_o              registered IFM SRAM write port
//   busy_o                       load in progress
//   finish_o                     one-cycle completion pulse
// -----------------------------------------------------------------------------
`ifndef BUS_SIZE
`define BUS_SIZE 8
`endif
`ifndef WR_DAT_CYC_NUM
`define WR_DAT_CYC_NUM 4
`endif
`ifndef SRAM_IFM_NUM
`define SRAM_IFM_NUM 8
`endif
`ifndef SRAM_FILTER_NUM
`define SRAM_FILTER_NUM 8
`endif

module sram_load_sched
    import npu_mem_pkg::*;
#(
    parameter int BUS_SIZE        = `BUS_SIZE,
    parameter int WR_DAT_CYC_NUM  = `WR_DAT_CYC_NUM,
    parameter int SRAM_IFM_NUM    = `SRAM_IFM_NUM,
    parameter int SRAM_FILTER_NUM = `SRAM_FILTER_NUM
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                start_i,
    input  logic [$clog2(SRAM_FILTER_NUM):0]    fil_chunk_num_i,
    input  logic [$clog2(SRAM_IFM_NUM):0]       ifm_chunk_num_i,
    input  logic                                in_valid_i,
    output logic                                in_ready_o,
    input  logic [BUS_SIZE-1:0]                 in_sparsemap_i,
    input  logic [BUS_SIZE*8-1:0]               in_nonzero_data_i,
    output logic [BUS_SIZE-1:0]                 fil_sram_wr_sparsemap_o,
    output logic [BUS_SIZE*8-1:0]               fil_sram_wr_nonzero_data_o,
    output logic                                fil_sram_wr_valid_o,
    output logic [$clog2(WR_DAT_CYC_NUM)-1:0]   fil_sram_wr_dat_count_o,
    output logic [$clog2(SRAM_FILTER_NUM)-1:0]  fil_sram_wr_chunk_count_o,
    output logic [BUS_SIZE-1:0]                 ifm_sram_wr_sparsemap_o,
    output logic [BUS_SIZE*8-1:0]               ifm_sram_wr_nonzero_data_o,
    output logic                                ifm_sram_wr_valid_o,
    output logic [$clog2(WR_DAT_CYC_NUM)-1:0]   ifm_sram_wr_dat_count_o,
    output logic [$clog2(SRAM_IFM_NUM)-1:0]     ifm_sram_wr_chunk_count_o,
    output logic                                busy_o,
    output logic                                finish_o
);

    localparam int DW  = $clog2(WR_DAT_CYC_NUM);
    localparam int FCW = $clog2(SRAM_FILTER_NUM);
    localparam int ICW = $clog2(SRAM_IFM_NUM);
    localparam logic [FCW:0] FIL_CAP = (FCW + 1)'(SRAM_FILTER_NUM);
    localparam logic [ICW:0] IFM_CAP = (ICW + 1)'(SRAM_IFM_NUM);

    sched_state_e state_q, state_d;

    logic [FCW:0]  fil_num_q, fil_num_sat;
    logic [ICW:0]  ifm_num_q, ifm_num_sat;
    logic          start_acc, accept, fil_inc, ifm_inc;
    logic [DW-1:0] fil_dat, ifm_dat;
    logic [FCW-1:0] fil_chunk;
    logic [ICW-1:0] ifm_chunk;
    logic          fil_last, ifm_last;

    // Saturate requested counts to the SRAM capacity before they are latched.
    assign fil_num_sat = (fil_chunk_num_i > FIL_CAP) ? FIL_CAP : fil_chunk_num_i;
    assign ifm_num_sat = (ifm_chunk_num_i > IFM_CAP) ? IFM_CAP : ifm_chunk_num_i;

    assign start_acc  = (state_q == ST_IDLE) && start_i;
    // Ready depends only on the state register, never on in_valid_i.
    assign in_ready_o = (state_q == ST_LOAD_FIL) || (state_q == ST_LOAD_IFM);
    assign accept     = in_valid_i && in_ready_o;
    assign fil_inc    = accept && (state_q == ST_LOAD_FIL);
    assign ifm_inc    = accept && (state_q == ST_LOAD_IFM);
    assign busy_o     = (state_q != ST_IDLE);
    assign finish_o   = (state_q == ST_DONE);

    sram_wr_addr_cnt #(
        .DAT_NUM   (WR_DAT_CYC_NUM),
        .CHUNK_NUM (SRAM_FILTER_NUM)
    ) u_fil_cnt (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clr_i       (start_acc),
        .inc_i       (fil_inc),
        .chunk_num_i (fil_num_q),
        .dat_o       (fil_dat),
        .chunk_o     (fil_chunk),
        .last_o      (fil_last)
    );

    sram_wr_addr_cnt #(
        .DAT_NUM   (WR_DAT_CYC_NUM),
        .CHUNK_NUM (SRAM_IFM_NUM)
    ) u_ifm_cnt (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clr_i       (start_acc),
        .inc_i       (ifm_inc),
        .chunk_num_i (ifm_num_q),
        .dat_o       (ifm_dat),
        .chunk_o     (ifm_chunk),
        .last_o      (ifm_last)
    );

    // Next-state logic. Empty phases are skipped so no cycle is spent in a
    // load state that has nothing to accept.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    if (fil_num_sat != '0)      state_d = ST_LOAD_FIL;
                    else if (ifm_num_sat != '0) state_d = ST_LOAD_IFM;
                    else                        state_d = ST_DONE;
                end
            end
            ST_LOAD_FIL: begin
                if (fil_inc && fil_last) begin
                    state_d = (ifm_num_q != '0) ? ST_LOAD_IFM : ST_DONE;
                end
            end
            ST_LOAD_IFM: begin
                if (ifm_inc && ifm_last) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q   <= ST_IDLE;
            fil_num_q <= '0;
            ifm_num_q <= '0;
        end else begin
            state_q <= state_d;
            if (start_acc) begin
                fil_num_q <= fil_num_sat;
                ifm_num_q <= ifm_num_sat;
            end
        end
    end

    // Registered write ports: one cycle after acceptance, carrying the beat
    // and the address it was accepted at.
    always_ff @(posedge clk_i) begin
        // NOTE: payload registers are reset as well, so the write ports read all-zero out of reset.
        if (!rst_i) begin
            fil_sram_wr_valid_o        <= 1'b0;
            fil_sram_wr_sparsemap_o    <= '0;
            fil_sram_wr_nonzero_data_o <= '0;
            fil_sram_wr_dat_count_o    <= '0;
            fil_sram_wr_chunk_count_o  <= '0;
            ifm_sram_wr_valid_o        <= 1'b0;
            ifm_sram_wr_sparsemap_o    <= '0;
            ifm_sram_wr_nonzero_data_o <= '0;
            ifm_sram_wr_dat_count_o    <= '0;
            ifm_sram_wr_chunk_count_o  <= '0;
        end else begin
            fil_sram_wr_valid_o <= fil_inc;
            ifm_sram_wr_valid_o <= ifm_inc;
            if (fil_inc) begin
                fil_sram_wr_sparsemap_o    <= in_sparsemap_i;
                fil_sram_wr_nonzero_data_o <= in_nonzero_data_i;
                fil_sram_wr_dat_count_o    <= fil_dat;
                fil_sram_wr_chunk_count_o  <= fil_chunk;
            end
            if (ifm_inc) begin
                ifm_sram_wr_sparsemap_o    <= in_sparsemap_i;
                ifm_sram_wr_nonzero_data_o <= in_nonzero_data_i;
                ifm_sram_wr_dat_count_o    <= ifm_dat;
                ifm_sram_wr_chunk_count_o  <= ifm_chunk;
            end
        end
    end

endmodule : sram_load_sched

// File: tb/tb_sram_load_sched.sv
// -----------------------------------------------------------------------------
// tb_sram_load_sched
// Self-checking bench for sram_load_sched (WR_DAT_CYC_NUM = 4, 8-chunk SRAMs).
// Expected write streams come from a beat-index model: the k-th accepted beat
// of a load goes to the filter port while k < 4*fil, else to the IFM port,
// at chunk = j/4, dat = j%4 of its phase, carrying the k-th accepted payload.
// -----------------------------------------------------------------------------
module tb_sram_load_sched;

    localparam int BUS  = 8;
    localparam int NDAT = 4;
    localparam int NIFM = 8;
    localparam int NFIL = 8;
    localparam int FCW  = $clog2(NFIL);
    localparam int ICW  = $clog2(NIFM);
    localparam int DW   = $clog2(NDAT);

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [FCW:0]       fil_num;
    logic [ICW:0]       ifm_num;
    logic               in_valid;
    logic               in_ready;
    logic [BUS-1:0]     smap;
    logic [BUS*8-1:0]   nzd;
    logic [BUS-1:0]     fil_sm, ifm_sm;
    logic [BUS*8-1:0]   fil_nz, ifm_nz;
    logic               fil_v, ifm_v;
    logic [DW-1:0]      fil_dat, ifm_dat;
    logic [FCW-1:0]     fil_chk;
    logic [ICW-1:0]     ifm_chk;
    logic               busy, finish;

    always #5 clk = ~clk;

    sram_load_sched #(
        .BUS_SIZE        (BUS),
        .WR_DAT_CYC_NUM  (NDAT),
        .SRAM_IFM_NUM    (NIFM),
        .SRAM_FILTER_NUM (NFIL)
    ) dut (
        .clk_i                      (clk),
        .rst_i                      (rst),
        .start_i                    (start),
        .fil_chunk_num_i            (fil_num),
        .ifm_chunk_num_i            (ifm_num),
        .in_valid_i                 (in_valid),
        .in_ready_o                 (in_ready),
        .in_sparsemap_i             (smap),
        .in_nonzero_data_i          (nzd),
        .fil_sram_wr_sparsemap_o    (fil_sm),
        .fil_sram_wr_nonzero_data_o (fil_nz),
        .fil_sram_wr_valid_o        (fil_v),
        .fil_sram_wr_dat_count_o    (fil_dat),
        .fil_sram_wr_chunk_count_o  (fil_chk),
        .ifm_sram_wr_sparsemap_o    (ifm_sm),
        .ifm_sram_wr_nonzero_data_o (ifm_nz),
        .ifm_sram_wr_valid_o        (ifm_v),
        .ifm_sram_wr_dat_count_o    (ifm_dat),
        .ifm_sram_wr_chunk_count_o  (ifm_chk),
        .busy_o                     (busy),
        .finish_o                   (finish)
    );

    typedef struct {
        bit          is_ifm;
        int          chunk;
        int          dat;
        logic [7:0]  sm;
        logic [63:0] nz;
    } beat_t;

    // Table vector: counts, source mode (0 always valid, 1 toggle, 2 random),
    // hand-computed beat total, and whether to re-pulse start during IFM load.
    typedef struct {
        int fil;
        int ifm;
        int mode;
        int exp_beats;
        bit poke;
    } vec_t;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " fil_v"},   64'(fil_v), 64'd0);
        check({tag, " ifm_v"},   64'(ifm_v), 64'd0);
        check({tag, " busy"},    64'(busy), 64'd0);
        check({tag, " finish"},  64'(finish), 64'd0);
        check({tag, " ready"},   64'(in_ready), 64'd0);
        check({tag, " payload"}, fil_nz | ifm_nz | 64'(fil_sm) | 64'(ifm_sm), 64'd0);
        check({tag, " counts"},  64'({fil_dat, fil_chk, ifm_dat, ifm_chk}), 64'd0);
    endtask

    task automatic run_load(input int fil, input int ifm, input int mode,
                            input int exp_beats, input bit poke, input string tag);
        beat_t exp_q[$];
        beat_t got_q[$];
        beat_t b;
        int    n_fil, n_ifm, idx, k;
        int    fin_cnt, fin_at, last_wr_at, cyc, busy_cyc;
        bit    ready_seen, poked, v;

        n_fil = (fil > NFIL) ? NFIL : fil;
        n_ifm = (ifm > NIFM) ? NIFM : ifm;
        fin_cnt = 0; fin_at = -1; last_wr_at = -1; cyc = 0; busy_cyc = 0;
        ready_seen = 0; poked = 0;

        start    = 1'b1;
        fil_num  = (FCW + 1)'(fil);
        ifm_num  = (ICW + 1)'(ifm);
        in_valid = 1'b0;
        step();
        start = 1'b0;

        while (cyc < 3000) begin
            check({tag, " one port"}, 64'(fil_v & ifm_v), 64'd0);
            if (fil_v) begin
                b = '{0, int'(fil_chk), int'(fil_dat), fil_sm, fil_nz};
                got_q.push_back(b);
                last_wr_at = cyc;
            end
            if (ifm_v) begin
                b = '{1, int'(ifm_chk), int'(ifm_dat), ifm_sm, ifm_nz};
                got_q.push_back(b);
                last_wr_at = cyc;
            end
            if (finish) begin
                fin_cnt++;
                fin_at = cyc;
            end
            if (busy) busy_cyc++;
            if (!busy) break;
            if (in_ready) ready_seen = 1;

            // Re-request with different counts once the IFM phase is running.
            start = 1'b0;
            if (poke && !poked && ifm_v) begin
                start   = 1'b1;
                fil_num = 4'd3;
                ifm_num = 4'd5;
                poked   = 1;
            end

            case (mode)
                0:       v = 1'b1;
                1:       v = (cyc % 2) == 0;
                default: v = ($urandom_range(0, 2) != 0);
            endcase
            in_valid = v;
            smap     = BUS'($urandom);
            nzd      = {$urandom, $urandom};
            if (v && in_ready) begin
                idx = exp_q.size();
                b.is_ifm = (idx >= n_fil * NDAT);
                k        = b.is_ifm ? idx - n_fil * NDAT : idx;
                b.chunk  = k / NDAT;
                b.dat    = k % NDAT;
                b.sm     = smap;
                b.nz     = nzd;
                exp_q.push_back(b);
            end
            step();
            cyc++;
        end
        start    = 1'b0;
        in_valid = 1'b0;

        check({tag, " terminated"}, 64'(busy), 64'd0);
        check({tag, " beats vs table"}, 64'(got_q.size()), 64'(exp_beats));
        check({tag, " beats vs model"}, 64'(exp_q.size()), 64'(4 * (n_fil + n_ifm)));
        check({tag, " finish count"}, 64'(fin_cnt), 64'd1);
        if (exp_beats != 0) begin
            check({tag, " finish with last write"}, 64'(fin_at), 64'(last_wr_at));
        end else begin
            check({tag, " ready never"}, 64'(ready_seen), 64'd0);
            check({tag, " busy cycles"}, 64'(busy_cyc), 64'd1);
        end
        if (mode == 0) check({tag, " no bubbles"}, 64'(fin_at), 64'(exp_beats));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            check($sformatf("%s beat%0d addr", tag, i),
                  64'({got_q[i].is_ifm, 8'(got_q[i].chunk), 8'(got_q[i].dat)}),
                  64'({exp_q[i].is_ifm, 8'(exp_q[i].chunk), 8'(exp_q[i].dat)}));
            check($sformatf("%s beat%0d nz", tag, i), got_q[i].nz, exp_q[i].nz);
            check($sformatf("%s beat%0d sm", tag, i), 64'(got_q[i].sm), 64'(exp_q[i].sm));
        end
    endtask

    vec_t vt[6];

    initial begin
        bit reached;
        int f, m;

        vt[0] = '{2, 3, 0, 20, 0};
        vt[1] = '{0, 1, 0, 4, 0};
        vt[2] = '{0, 0, 0, 0, 0};
        vt[3] = '{1, 1, 1, 8, 0};
        vt[4] = '{2, 2, 0, 16, 1};
        vt[5] = '{12, 15, 2, 64, 0};

        rst = 1'b0; start = 1'b0; fil_num = '0; ifm_num = '0;
        in_valid = 1'b0; smap = '0; nzd = '0;
        step(); step();
        check_all_zero("reset");
        rst = 1'b1;
        step();
        check_all_zero("idle");

        for (int i = 0; i < 6; i++) begin
            run_load(vt[i].fil, vt[i].ifm, vt[i].mode, vt[i].exp_beats, vt[i].poke,
                     $sformatf("vec%0d", i));
            step();
        end

        // Reset in the middle of filter chunk 1 aborts without a finish pulse.
        start = 1'b1; fil_num = 4'd2; ifm_num = 4'd1;
        step();
        start = 1'b0; in_valid = 1'b1; nzd = 64'h1234; smap = 8'h5a;
        reached = 0;
        for (int c = 0; c < 50 && !reached; c++) begin
            step();
            if (fil_v && fil_chk == 1) reached = 1;
        end
        check("midload reached chunk1", 64'(reached), 64'd1);
        rst = 1'b0; in_valid = 1'b0;
        step();
        check_all_zero("midload reset");
        rst = 1'b1;
        step();
        check("post reset finish", 64'(finish), 64'd0);
        run_load(1, 0, 0, 4, 0, "after reset");
        step();

        for (int r = 0; r < 12; r++) begin
            f = $urandom_range(0, 10);
            m = $urandom_range(0, 10);
            run_load(f, m, 2, 4 * ((f > NFIL ? NFIL : f) + (m > NIFM ? NIFM : m)), 0,
                     $sformatf("rand%0d", r));
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_sram_load_sched
